// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// Registered ALU-control decode stage between IFU and EXU. Decodes RV32I
// (and RV32M when EN_M=1) into a 5-bit ALU opcode plus illegal and
// multi-cycle flags. A 2-entry skid buffer keeps in_ready a pure register
// output, so there is no combinational path from out_ready to in_ready.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous flush, empties the stage
//   in_valid/in_ready   upstream handshake; in_inst, in_pc payload
//   out_valid/out_ready downstream handshake
//   out_alu_ctrl        decoded ALU opcode
//   out_inst, out_pc    pass-through instruction and PC
//   out_illegal         instruction could not be decoded
//   out_multicycle      op needs the iterative divider
//   illegal_cnt         saturating count of illegal instructions delivered
module alu_decode_stage #(
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_alu_ctrl,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic             out_multicycle,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_PASSB = 5'b00001;
  localparam logic [4:0] ALU_SUB   = 5'b00010;
  localparam logic [4:0] ALU_JALR  = 5'b00011;
  localparam logic [4:0] ALU_SLTU  = 5'b00100;
  localparam logic [4:0] ALU_XOR   = 5'b00101;
  localparam logic [4:0] ALU_OR    = 5'b00110;
  localparam logic [4:0] ALU_AND   = 5'b00111;
  localparam logic [4:0] ALU_SLL   = 5'b01000;
  localparam logic [4:0] ALU_SRA   = 5'b01001;
  localparam logic [4:0] ALU_SRL   = 5'b01010;
  localparam logic [4:0] ALU_SLT   = 5'b01100;
  localparam logic [4:0] ALU_BR    = 5'b01101;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [4:0]      ctrl;
    logic            illegal;
    logic            multi;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } payload_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] dec_ctrl;
  logic       dec_bad;
  logic       dec_multi;
  payload_t   dec_pl;

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  payload_t         out_q, out_d;
  payload_t         skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_xfer;
  logic out_xfer;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  always_comb begin
    dec_ctrl = ALU_ADD;
    dec_bad  = 1'b0;
    case (opcode)
      OPC_LUI:            dec_ctrl = ALU_PASSB;
      OPC_AUIPC, OPC_JAL: dec_ctrl = ALU_ADD;
      OPC_JALR: begin
        dec_ctrl = ALU_JALR;
        dec_bad  = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_ctrl = ALU_BR;
        dec_bad  = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      // lb/lh/lw/lbu/lhu only
      OPC_LOAD:  dec_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      // sb/sh/sw only
      OPC_STORE: dec_bad = funct3[2] || (funct3[1:0] == 2'b11);
      OPC_OPIMM: begin
        case (funct3)
          3'b000: dec_ctrl = ALU_ADD;
          3'b010: dec_ctrl = ALU_SLT;
          3'b011: dec_ctrl = ALU_SLTU;
          3'b100: dec_ctrl = ALU_XOR;
          3'b110: dec_ctrl = ALU_OR;
          3'b111: dec_ctrl = ALU_AND;
          3'b001: begin
            dec_ctrl = ALU_SLL;
            dec_bad  = (funct7 != F7_ZERO);
          end
          default: begin
            // funct3 = 101: imm[11:5] selects logical vs arithmetic shift
            if (funct7 == F7_ZERO)     dec_ctrl = ALU_SRL;
            else if (funct7 == F7_ALT) dec_ctrl = ALU_SRA;
            else                       dec_bad  = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        case (funct7)
          F7_ZERO: begin
            case (funct3)
              3'b000:  dec_ctrl = ALU_ADD;
              3'b001:  dec_ctrl = ALU_SLL;
              3'b010:  dec_ctrl = ALU_SLT;
              3'b011:  dec_ctrl = ALU_SLTU;
              3'b100:  dec_ctrl = ALU_XOR;
              3'b101:  dec_ctrl = ALU_SRL;
              3'b110:  dec_ctrl = ALU_OR;
              default: dec_ctrl = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (funct3 == 3'b000)      dec_ctrl = ALU_SUB;
            else if (funct3 == 3'b101) dec_ctrl = ALU_SRA;
            else                       dec_bad  = 1'b1;
          end
          F7_MUL: begin
            // M-extension opcodes are 10 followed by funct3
            if (EN_M) dec_ctrl = {2'b10, funct3};
            else      dec_bad  = 1'b1;
          end
          default: dec_bad = 1'b1;
        endcase
      end
      default: dec_bad = 1'b1;
    endcase
    if (dec_bad) dec_ctrl = ALU_ADD;
  end

  // DIV/DIVU/REM/REMU share the 101xx opcode prefix
  assign dec_multi = EN_M && !dec_bad && (dec_ctrl[4:2] == 3'b101);

  always_comb begin
    dec_pl         = '0;
    dec_pl.ctrl    = dec_ctrl;
    dec_pl.illegal = dec_bad;
    dec_pl.multi   = dec_multi;
    dec_pl.inst    = in_inst;
    dec_pl.pc      = in_pc;
  end

  assign in_xfer  = in_valid && !skid_valid_q;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    cnt_d        = cnt_q;

    // Counting follows delivered transfers, so flush does not touch it
    if (out_xfer && out_q.illegal && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only draining can happen
      if (out_ready) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!out_valid_q || out_ready) begin
        out_d       = dec_pl;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = dec_pl;
        skid_valid_d = 1'b1;
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready       = !skid_valid_q;
  assign out_valid      = out_valid_q;
  assign out_alu_ctrl   = out_q.ctrl;
  assign out_inst       = out_q.inst;
  assign out_pc         = out_q.pc;
  assign out_illegal    = out_q.illegal;
  assign out_multicycle = out_q.multi;
  assign illegal_cnt    = cnt_q;

endmodule
